// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - four-phase instruction sequencer driving integer_datapath
//
// Purpose: accepts one 16-bit instruction per Instr_Valid/Instr_Rdy handshake,
// decodes it into datapath controls and performs exactly one write-back per
// instruction, capturing the resulting ALU flags and counting retirements.
//
// Ports:
//   Clk, Reset                 clock, asynchronous active-low reset
//   Instr, Instr_Valid         instruction offer from upstream
//   Instr_Rdy                  high only while idle
//   N_In, Z_In, C_In           ALU flags from the datapath
//   W_En, W_Adr, R_Adr, S_Adr  register-file controls
//   S_Sel, DS                  S operand source select and sign-extended immediate
//   ALU_OP                     ALU operation code
//   Flags                      {N,Z,C} of the last retired instruction
//   Done                       one-cycle pulse per retired instruction
//   Instr_Cnt                  retired-instruction count (wraps)

module cpu_control_unit #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       Instr,
  input  logic              Instr_Valid,
  output logic              Instr_Rdy,
  input  logic              N_In,
  input  logic              Z_In,
  input  logic              C_In,
  output logic              W_En,
  output logic [2:0]        W_Adr,
  output logic [2:0]        R_Adr,
  output logic [2:0]        S_Adr,
  output logic              S_Sel,
  output logic [DATA_W-1:0] DS,
  output logic [3:0]        ALU_OP,
  output logic [2:0]        Flags,
  output logic              Done,
  output logic [CNT_W-1:0]  Instr_Cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DECODE  = 2'd1;
  localparam logic [1:0] S_EXECUTE = 2'd2;
  localparam logic [1:0] S_RETIRE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Instr_Valid) begin
          ir_d    = Instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        // Flags are taken at the same edge the register file commits the write.
        flags_d = {N_In, Z_In, C_In};
        state_d = S_RETIRE;
      end
      S_RETIRE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode registers only. IR is loaded at the handshake edge, so the
  // decoded fields are already valid in DECODE and persist through IDLE until the
  // next handshake; a reset clears IR and so zeroes every field.
  assign Instr_Rdy = (state_q == S_IDLE);
  assign W_En      = (state_q == S_EXECUTE);
  assign Done      = (state_q == S_RETIRE);
  assign ALU_OP    = ir_q[15:12];
  assign W_Adr     = ir_q[11:9];
  assign R_Adr     = ir_q[8:6];
  assign S_Sel     = ir_q[5];
  // Immediate mode forces S_Adr to 0; register mode forces DS to 0.
  assign S_Adr     = ir_q[5] ? 3'd0 : ir_q[2:0];
  assign DS        = ir_q[5] ? {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]}
                             : '0;
  assign Flags     = flags_q;
  assign Instr_Cnt = cnt_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - self-checking bench for cpu_control_unit

module tb_cpu_control_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Instr;
  logic        Instr_Valid;
  logic        N_In, Z_In, C_In;

  logic        Instr_Rdy, W_En, S_Sel, Done;
  logic [2:0]  W_Adr, R_Adr, S_Adr, Flags;
  logic [15:0] DS;
  logic [3:0]  ALU_OP;
  logic [15:0] Instr_Cnt;

  logic        s_rdy, s_wen, s_ssel, s_done;
  logic [2:0]  s_wadr, s_radr, s_sadr, s_flags;
  logic [15:0] s_ds;
  logic [3:0]  s_op;
  logic [2:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_ir;
  logic [2:0]  exp_flags;
  int          exp_cnt;

  always #5 Clk = ~Clk;

  cpu_control_unit dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Instr_Valid(Instr_Valid),
    .Instr_Rdy(Instr_Rdy), .N_In(N_In), .Z_In(Z_In), .C_In(C_In),
    .W_En(W_En), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr), .S_Sel(S_Sel),
    .DS(DS), .ALU_OP(ALU_OP), .Flags(Flags), .Done(Done), .Instr_Cnt(Instr_Cnt)
  );

  // Narrow-counter instance sharing all inputs, used to observe counter wrap.
  cpu_control_unit #(.CNT_W(3)) dut_small (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Instr_Valid(Instr_Valid),
    .Instr_Rdy(s_rdy), .N_In(N_In), .Z_In(Z_In), .C_In(C_In),
    .W_En(s_wen), .W_Adr(s_wadr), .R_Adr(s_radr), .S_Adr(s_sadr), .S_Sel(s_ssel),
    .DS(s_ds), .ALU_OP(s_op), .Flags(s_flags), .Done(s_done), .Instr_Cnt(s_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the instruction format, using plain arithmetic.
  task automatic check_fields();
    int op, wa, ra, mode, sa, imm;
    logic [15:0] ds;
    op   = exp_ir / 4096;
    wa   = (exp_ir / 512) % 8;
    ra   = (exp_ir / 64) % 8;
    mode = (exp_ir / 32) % 2;
    imm  = exp_ir % 32;
    if (imm >= 16) imm = imm - 32;
    sa   = (mode == 1) ? 0 : exp_ir % 8;
    ds   = (mode == 1) ? 16'(imm) : 16'd0;
    chk("alu_op", 32'(ALU_OP), 32'(op));
    chk("w_adr",  32'(W_Adr),  32'(wa));
    chk("r_adr",  32'(R_Adr),  32'(ra));
    chk("s_adr",  32'(S_Adr),  32'(sa));
    chk("s_sel",  32'(S_Sel),  32'(mode));
    chk("ds",     32'(DS),     32'(ds));
  endtask

  task automatic check_counts();
    chk("instr_cnt",  32'(Instr_Cnt), 32'(exp_cnt % 65536));
    chk("cnt_small",  32'(s_cnt),     32'(exp_cnt % 8));
    chk("flags",      32'(Flags),     32'(exp_flags));
  endtask

  task automatic rand_flags();
    {N_In, Z_In, C_In} = 3'($urandom);
  endtask

  // Entered at a falling edge while idle; returns at the falling edge of the next idle cycle
  // with Instr_Valid still high so consecutive calls run back-to-back.
  task automatic do_instr(input logic [15:0] w, input bit fixed, input logic [2:0] ff);
    chk("rdy_idle",  32'(Instr_Rdy), 1);
    chk("wen_idle",  32'(W_En), 0);
    chk("done_idle", 32'(Done), 0);
    check_fields();
    check_counts();
    Instr = w; Instr_Valid = 1'b1; rand_flags();
    @(negedge Clk);
    exp_ir = w;
    Instr = 16'($urandom);
    chk("rdy_dec",  32'(Instr_Rdy), 0);
    chk("wen_dec",  32'(W_En), 0);
    chk("done_dec", 32'(Done), 0);
    check_fields();
    @(negedge Clk);
    Instr = 16'($urandom);
    chk("wen_exe",  32'(W_En), 1);
    chk("done_exe", 32'(Done), 0);
    chk("rdy_exe",  32'(Instr_Rdy), 0);
    check_fields();
    if (fixed) {N_In, Z_In, C_In} = ff;
    else rand_flags();
    exp_flags = {N_In, Z_In, C_In};
    @(negedge Clk);
    chk("done_ret", 32'(Done), 1);
    chk("wen_ret",  32'(W_En), 0);
    chk("rdy_ret",  32'(Instr_Rdy), 0);
    check_fields();
    check_counts();
    rand_flags();
    exp_cnt++;
    @(negedge Clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      Instr_Valid = 1'b0; rand_flags();
      chk("rdy_quiet",  32'(Instr_Rdy), 1);
      chk("wen_quiet",  32'(W_En), 0);
      chk("done_quiet", 32'(Done), 0);
      check_fields();
      check_counts();
      @(negedge Clk);
    end
  endtask

  initial begin
    Reset = 1'b0; Instr = '0; Instr_Valid = 1'b0;
    N_In = 1'b0; Z_In = 1'b0; C_In = 1'b0;
    exp_ir = '0; exp_flags = '0; exp_cnt = 0;
    repeat (2) @(negedge Clk);
    chk("rst_wen",  32'(W_En), 0);
    chk("rst_done", 32'(Done), 0);
    check_fields();
    check_counts();
    Reset = 1'b1;
    @(negedge Clk);

    do_instr(16'h3A4B, 1'b0, 3'b000);
    do_instr(16'h1E3F, 1'b0, 3'b000);
    do_instr(16'h1E2F, 1'b0, 3'b000);
    do_instr(16'($urandom), 1'b1, 3'b011);
    idle_cycles(3);
    chk("flags_011", 32'(Flags), 32'h3);

    for (int i = 0; i < 20; i++) do_instr(16'($urandom), 1'b0, 3'b000);
    idle_cycles(1);

    // Reset in the middle of EXECUTE.
    Instr = 16'($urandom); Instr_Valid = 1'b1;
    @(negedge Clk);
    exp_ir = Instr;
    Instr_Valid = 1'b0;
    @(negedge Clk);
    chk("wen_pre_rst", 32'(W_En), 1);
    #1 Reset = 1'b0;
    #1;
    exp_ir = '0; exp_flags = '0; exp_cnt = 0;
    chk("wen_at_rst",  32'(W_En), 0);
    chk("done_at_rst", 32'(Done), 0);
    check_fields();
    check_counts();
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    idle_cycles(3);

    for (int i = 0; i < 10; i++) do_instr(16'($urandom), 1'b0, 3'b000);
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
